// File: rtl/display_timing_480p.sv
// Raster timing generator for 640x480@60: signed coordinates with blanking at negative
// positions, syncs, data enable and line/frame strobes, all registered and mutually aligned.
module display_timing_480p #(
    parameter int CORDW  = 16,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int H_FP   = 16,
    parameter int V_FP   = 10,
    parameter int H_SYNC = 96,
    parameter int V_SYNC = 2,
    parameter int H_BP   = 48,
    parameter int V_BP   = 33,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line
);

    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_STA = CORDW'(-(H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(-H_BP);
    localparam logic signed [CORDW-1:0] HA_END = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_STA = CORDW'(-(V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(-V_BP);
    localparam logic signed [CORDW-1:0] VA_END = CORDW'(V_RES - 1);
    localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);

    logic signed [CORDW-1:0] x_q, x_d, y_q, y_d;
    logic signed [CORDW-1:0] sx_q, sy_q;
    logic hsync_q, hsync_d, vsync_q, vsync_d;
    logic de_q, de_d, frame_q, frame_d, line_q, line_d;

    always_comb begin
        x_d = x_q + ONE;
        y_d = y_q;
        if (x_q == HA_END) begin
            x_d = H_STA;
            y_d = (y_q == VA_END) ? V_STA : y_q + ONE;
        end
    end

    // Output decodes look at the current counters so they line up with sx/sy after the edge.
    always_comb begin
        hsync_d = (x_q > HS_STA && x_q <= HS_END) ? H_POL : ~H_POL;
        vsync_d = (y_q > VS_STA && y_q <= VS_END) ? V_POL : ~V_POL;
        de_d    = ~x_q[CORDW-1] & ~y_q[CORDW-1];
        frame_d = (x_q == H_STA) && (y_q == V_STA);
        line_d  = (x_q == H_STA);
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            x_q     <= H_STA;
            y_q     <= V_STA;
            sx_q    <= H_STA;
            sy_q    <= V_STA;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            frame_q <= 1'b0;
            line_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            sx_q    <= x_q;
            sy_q    <= y_q;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            frame_q <= frame_d;
            line_q  <= line_d;
        end
    end

    assign sx    = sx_q;
    assign sy    = sy_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign frame = frame_q;
    assign line  = line_q;

endmodule

// File: tb/tb_display_timing_480p.sv
// Bench for display_timing_480p: full 480p instance for line/blanking timing, plus two small
// raster instances (25x14 total, both sync polarities) for frame period, wrap and mid-frame reset.
module tb_display_timing_480p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst, s_rst;
    logic signed [15:0] sx, sy, s_sx, s_sy, p_sx, p_sy;
    logic hsync, vsync, de, frame, line;
    logic s_hsync, s_vsync, s_de, s_frame, s_line;
    logic p_hsync, p_vsync, p_de, p_frame, p_line;

    display_timing_480p dut (
        .clk_pix(clk), .rst_pix(rst), .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync),
        .de(de), .frame(frame), .line(line)
    );

    // Small raster: H_STA=-9, hsync x -6..-4, HA_END=15; V_STA=-6, vsync y -4..-3, VA_END=7.
    display_timing_480p #(
        .H_RES(16), .V_RES(8), .H_FP(2), .V_FP(1), .H_SYNC(3), .V_SYNC(2), .H_BP(4), .V_BP(3)
    ) dut_s (
        .clk_pix(clk), .rst_pix(s_rst), .sx(s_sx), .sy(s_sy), .hsync(s_hsync), .vsync(s_vsync),
        .de(s_de), .frame(s_frame), .line(s_line)
    );

    display_timing_480p #(
        .H_RES(16), .V_RES(8), .H_FP(2), .V_FP(1), .H_SYNC(3), .V_SYNC(2), .H_BP(4), .V_BP(3),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_p (
        .clk_pix(clk), .rst_pix(s_rst), .sx(p_sx), .sy(p_sy), .hsync(p_hsync), .vsync(p_vsync),
        .de(p_de), .frame(p_frame), .line(p_line)
    );

    task automatic test_reset();
        rst = 1'b1;
        s_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sx !== -16'sd160 || sy !== -16'sd45) begin
            errors++; $display("FAIL reset_coord sx=%0d sy=%0d want -160 -45", sx, sy);
        end
        checks++;
        if ({hsync, vsync, de, frame, line} !== 5'b11000) begin
            errors++; $display("FAIL reset_flags hs/vs/de/fr/ln=%b want 11000", {hsync, vsync, de, frame, line});
        end
        checks++;
        if (p_hsync !== 1'b0 || p_vsync !== 1'b0) begin
            errors++; $display("FAIL reset_pol hs=%b vs=%b want 0 0", p_hsync, p_vsync);
        end
        rst = 1'b0;
        s_rst = 1'b0;
    endtask

    task automatic test_first_wrap();
        int n = 0;
        @(negedge clk);
        while (sx !== 16'sd639 && n < 1000) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        checks++;
        if (sx !== -16'sd160 || sy !== -16'sd44 || line !== 1'b1) begin
            errors++; $display("FAIL first_wrap sx=%0d sy=%0d line=%b want -160 -44 1", sx, sy, line);
        end
    endtask

    // Vertical blanking of the 480p raster: from sy=-44 up to the first active pixel.
    task automatic test_vblank();
        int n = 0, vs_lo = 0, de_hi = 0, lines = 0;
        logic signed [15:0] px, py;
        bit seen = 0;
        px = sx; py = sy;
        if (!vsync) vs_lo++;
        if (line) lines++;
        while (!(sx === 16'sd0 && sy === 16'sd0) && n < 50000) begin
            @(negedge clk); n++;
            if (px === 16'sd639 && py === -16'sd1) begin
                seen = 1;
                checks++;
                if (sy !== 16'sd0 || sx !== -16'sd160) begin
                    errors++; $display("FAIL vis_start sx=%0d sy=%0d want -160 0", sx, sy);
                end
            end
            if (!vsync) vs_lo++;
            if (de && !(sx === 16'sd0 && sy === 16'sd0)) de_hi++;
            if (line) lines++;
            px = sx; py = sy;
        end
        checks++;
        if (n >= 50000 || !seen) begin
            errors++; $display("FAIL vblank_timeout n=%0d seen=%0d", n, seen);
        end
        checks++;
        if (de !== 1'b1) begin errors++; $display("FAIL de_rise de=%b want 1", de); end
        checks++;
        if (vs_lo != 1600) begin errors++; $display("FAIL vsync_width got=%0d want 1600", vs_lo); end
        checks++;
        if (de_hi != 0) begin errors++; $display("FAIL de_blank got=%0d want 0", de_hi); end
        checks++;
        if (lines != 45) begin errors++; $display("FAIL vblank_lines got=%0d want 45", lines); end
    endtask

    task automatic test_lines();
        int n = 0;
        while (line !== 1'b1 && n < 1000) begin
            @(negedge clk); n++;
        end
        for (int l = 0; l < 10; l++) begin
            int de_c = 0, hs_c = 0, ln_c = 0, de_first = -1, hs_bad = 0;
            bit ln0;
            ln0 = line;
            for (int i = 0; i < 800; i++) begin
                if (de) begin de_c++; if (de_first < 0) de_first = i; end
                if (!hsync) begin
                    hs_c++;
                    if (sx < -16'sd143 || sx > -16'sd48) hs_bad++;
                end
                if (line) ln_c++;
                @(negedge clk);
            end
            checks++;
            if (!ln0 || ln_c != 1) begin
                errors++; $display("FAIL line_period l=%0d first=%b cnt=%0d want 1 1", l, ln0, ln_c);
            end
            checks++;
            if (de_c != 640 || de_first != 160) begin
                errors++; $display("FAIL de_span l=%0d cnt=%0d first=%0d want 640 160", l, de_c, de_first);
            end
            checks++;
            if (hs_c != 96 || hs_bad != 0) begin
                errors++; $display("FAIL hsync_width l=%0d cnt=%0d bad=%0d want 96 0", l, hs_c, hs_bad);
            end
        end
    endtask

    task automatic s_wait_frame(output int n);
        n = 0;
        while (s_frame !== 1'b1 && n < 1000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 1000) begin errors++; $display("FAIL frame_timeout n=%0d", n); end
    endtask

    task automatic test_frames();
        int n;
        logic signed [15:0] px, py;
        s_wait_frame(n);
        for (int f = 0; f < 2; f++) begin
            int cyc = 0, vs_lo = 0, hs_lo = 0, phs = 0, pvs = 0, wraps = 0;
            checks++;
            if (s_sx !== -16'sd9 || s_sy !== -16'sd6 || s_line !== 1'b1) begin
                errors++; $display("FAIL frame_pos f=%0d sx=%0d sy=%0d line=%b want -9 -6 1", f, s_sx, s_sy, s_line);
            end
            do begin
                if (!s_vsync) vs_lo++;
                if (!s_hsync) hs_lo++;
                if (p_hsync) phs++;
                if (p_vsync) pvs++;
                px = s_sx; py = s_sy;
                @(negedge clk); cyc++;
                if (px === 16'sd15 && py === 16'sd7) begin
                    wraps++;
                    checks++;
                    if (s_sx !== -16'sd9 || s_sy !== -16'sd6) begin
                        errors++; $display("FAIL frame_wrap sx=%0d sy=%0d want -9 -6", s_sx, s_sy);
                    end
                end
            end while (s_frame !== 1'b1 && cyc < 1000);
            checks++;
            if (cyc != 350 || wraps != 1) begin
                errors++; $display("FAIL frame_period f=%0d got=%0d wraps=%0d want 350 1", f, cyc, wraps);
            end
            checks++;
            if (vs_lo != 50 || hs_lo != 42) begin
                errors++; $display("FAIL sync_counts vs=%0d hs=%0d want 50 42", vs_lo, hs_lo);
            end
            checks++;
            if (pvs != 50 || phs != 42) begin
                errors++; $display("FAIL pol_high vs=%0d hs=%0d want 50 42", pvs, phs);
            end
        end
    endtask

    task automatic test_midreset();
        int n = 0;
        logic signed [15:0] ex;
        while (!(s_sx === 16'sd10 && s_sy === 16'sd5) && n < 1000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 1000) begin errors++; $display("FAIL midreset_timeout n=%0d", n); end
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        checks++;
        if (s_sx !== -16'sd9 || s_sy !== -16'sd6 || s_de !== 1'b0 || {s_hsync, s_vsync} !== 2'b11) begin
            errors++; $display("FAIL midreset sx=%0d sy=%0d de=%b hs/vs=%b%b want -9 -6 0 11",
                               s_sx, s_sy, s_de, s_hsync, s_vsync);
        end
        checks++;
        if ({p_hsync, p_vsync} !== 2'b00) begin
            errors++; $display("FAIL midreset_pol hs/vs=%b%b want 00", p_hsync, p_vsync);
        end
        n = 0;
        ex = -16'sd9;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_sx !== ex) n++;
            ex = (ex == 16'sd15) ? -16'sd9 : ex + 16'sd1;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL resume_seq bad=%0d want 0", n); end
        s_wait_frame(n);
        n = 0;
        do begin @(negedge clk); n++; end while (s_frame !== 1'b1 && n < 1000);
        checks++;
        if (n != 350) begin errors++; $display("FAIL resume_period got=%0d want 350", n); end
    endtask

    initial begin
        rst = 1'b1;
        s_rst = 1'b1;
        test_reset();
        test_first_wrap();
        test_vblank();
        test_lines();
        test_frames();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
